// File: rtl/requant_round_sat.sv
// Multi-lane requantiser: optional arithmetic right shift with selectable rounding,
// saturation to OUT_W, 2-stage valid/ready pipeline and a saturating sat-event counter.
module requant_round_sat #(
    parameter int LANES   = 32,
    parameter int IN_W    = 16,
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [LANES*IN_W-1:0]    i_data,
    input  logic                     i_shift_en,
    input  logic [SHIFT_W-1:0]       i_shift,
    input  logic [1:0]               i_round_mode,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [LANES*OUT_W-1:0]   o_data,
    output logic [LANES-1:0]         o_sat,
    input  logic                     i_clr_cnt,
    output logic [CNT_W-1:0]         o_sat_cnt
);

    typedef enum logic [1:0] {
        RND_TRUNC     = 2'b00,
        RND_HALF_UP   = 2'b01,
        RND_HALF_EVEN = 2'b10,
        RND_HALF_AWAY = 2'b11
    } round_mode_e;

    localparam int SW   = $clog2(IN_W);
    localparam int MAXI = (1 << (OUT_W - 1)) - 1;
    localparam int MINI = -(1 << (OUT_W - 1));
    localparam logic signed [IN_W:0] Y_MAX = (IN_W + 1)'(MAXI);
    localparam logic signed [IN_W:0] Y_MIN = (IN_W + 1)'(MINI);

    logic [SW-1:0]            s_eff;
    logic [LANES*IN_W-1:0]    q1;
    logic [LANES-1:0]         inc1;
    logic [LANES*OUT_W-1:0]   data2;
    logic [LANES-1:0]         sat2;

    logic                     s1_valid_q, s1_valid_d;
    logic [LANES*IN_W-1:0]    s1_q_q, s1_q_d;
    logic [LANES-1:0]         s1_inc_q, s1_inc_d;
    logic                     o_valid_q, o_valid_d;
    logic [LANES*OUT_W-1:0]   o_data_q, o_data_d;
    logic [LANES-1:0]         o_sat_q, o_sat_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic adv1, adv2, in_xfer, out_xfer;
    logic [CNT_W:0] cnt_sum;

    // Shift amounts beyond the input width clamp to IN_W-1.
    always_comb begin
        s_eff = '0;
        if (i_shift_en) begin
            if (32'(i_shift) > IN_W - 1) s_eff = SW'(IN_W - 1);
            else                         s_eff = SW'(i_shift);
        end
    end

    // Stage 1: shift and derive guard/sticky/lsb to form the rounding increment.
    always_comb begin
        logic [IN_W-1:0] x;
        logic [IN_W-1:0] low_mask;
        logic g, r, l, sgn, inc;
        q1   = '0;
        inc1 = '0;
        for (int k = 0; k < LANES; k++) begin
            x        = i_data[k*IN_W +: IN_W];
            low_mask = '0;
            g        = 1'b0;
            r        = 1'b0;
            if (s_eff != '0) begin
                g        = x[s_eff - SW'(1)];
                low_mask = ((IN_W'(1) << s_eff) >> 1) - IN_W'(1);
                r        = |(x & low_mask);
            end
            l   = x[s_eff];
            sgn = x[IN_W-1];
            q1[k*IN_W +: IN_W] = $signed(x) >>> s_eff;
            case (round_mode_e'(i_round_mode))
                RND_TRUNC:     inc = 1'b0;
                RND_HALF_UP:   inc = g;
                RND_HALF_EVEN: inc = g & (r | l);
                RND_HALF_AWAY: inc = g & (r | ~sgn);
                default:       inc = 1'b0;
            endcase
            inc1[k] = inc & i_shift_en;
        end
    end

    // Stage 2: add in IN_W+1 bits so the saturation compare sees the true value.
    always_comb begin
        logic signed [IN_W:0] y;
        data2 = '0;
        sat2  = '0;
        for (int k = 0; k < LANES; k++) begin
            y = $signed({s1_q_q[k*IN_W + IN_W - 1], s1_q_q[k*IN_W +: IN_W]})
              + $signed({{IN_W{1'b0}}, s1_inc_q[k]});
            if (y > Y_MAX) begin
                data2[k*OUT_W +: OUT_W] = {1'b0, {(OUT_W - 1){1'b1}}};
                sat2[k]                 = 1'b1;
            end else if (y < Y_MIN) begin
                data2[k*OUT_W +: OUT_W] = {1'b1, {(OUT_W - 1){1'b0}}};
                sat2[k]                 = 1'b1;
            end else begin
                data2[k*OUT_W +: OUT_W] = y[OUT_W-1:0];
            end
        end
    end

    always_comb begin
        adv2     = ~o_valid_q | i_ready;
        adv1     = ~s1_valid_q | adv2;
        in_xfer  = i_valid & adv1;
        out_xfer = o_valid_q & i_ready;

        s1_valid_d = adv1 ? i_valid : s1_valid_q;
        s1_q_d     = in_xfer ? q1   : s1_q_q;
        s1_inc_d   = in_xfer ? inc1 : s1_inc_q;

        o_valid_d = adv2 ? s1_valid_q : o_valid_q;
        o_data_d  = (adv2 & s1_valid_q) ? data2 : o_data_q;
        o_sat_d   = (adv2 & s1_valid_q) ? sat2  : o_sat_q;

        cnt_sum = {1'b0, cnt_q} + (CNT_W + 1)'($countones(o_sat_q));
        cnt_d   = cnt_q;
        if (i_clr_cnt)     cnt_d = '0;
        else if (out_xfer) cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q <= 1'b0;
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
            o_sat_q    <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            o_valid_q  <= o_valid_d;
            o_data_q   <= o_data_d;
            o_sat_q    <= o_sat_d;
            cnt_q      <= cnt_d;
        end
    end

    // NOTE: stage-1 payload is qualified by s1_valid_q, so it needs no reset.
    always_ff @(posedge i_clk) begin
        s1_q_q   <= s1_q_d;
        s1_inc_q <= s1_inc_d;
    end

    assign o_ready   = adv1;
    assign o_valid   = o_valid_q;
    assign o_data    = o_data_q;
    assign o_sat     = o_sat_q;
    assign o_sat_cnt = cnt_q;

endmodule

// File: tb/tb_requant_round_sat.sv
// Scoreboard bench for requant_round_sat: an arithmetic reference model predicts each
// beat at input transfer; outputs are popped and compared at output transfer.
module tb_requant_round_sat;

    localparam int LANES   = 32;
    localparam int IN_W    = 16;
    localparam int OUT_W   = 8;
    localparam int SHIFT_W = 5;
    localparam int CNT_W   = 16;

    logic                   i_clk = 1'b0;
    logic                   i_rst_n;
    logic                   i_valid;
    logic                   o_ready;
    logic [LANES*IN_W-1:0]  i_data;
    logic                   i_shift_en;
    logic [SHIFT_W-1:0]     i_shift;
    logic [1:0]             i_round_mode;
    logic                   o_valid;
    logic                   i_ready;
    logic [LANES*OUT_W-1:0] o_data;
    logic [LANES-1:0]       o_sat;
    logic                   i_clr_cnt;
    logic [CNT_W-1:0]       o_sat_cnt;

    requant_round_sat #(
        .LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W), .CNT_W(CNT_W)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_shift_en(i_shift_en), .i_shift(i_shift),
        .i_round_mode(i_round_mode), .o_valid(o_valid), .i_ready(i_ready),
        .o_data(o_data), .o_sat(o_sat), .i_clr_cnt(i_clr_cnt), .o_sat_cnt(o_sat_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [LANES*OUT_W-1:0] d;
        logic [LANES-1:0]       s;
        logic                   has_dir;
        logic [OUT_W-1:0]       dir_d;
        logic                   dir_s;
        string                  tag;
    } exp_t;

    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    int    exp_cnt = 0;
    logic  prev_stall = 1'b0;
    logic [LANES*OUT_W-1:0] prev_data;
    logic [LANES-1:0]       prev_sat;
    logic  ready_rand = 1'b0;

    logic             cur_has_dir = 1'b0;
    logic [OUT_W-1:0] cur_dir_d;
    logic             cur_dir_s;
    string            cur_tag = "";

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: floor division plus remainder-vs-half comparison per mode.
    function automatic void model(input logic [LANES*IN_W-1:0] d, input logic en,
                                  input logic [SHIFT_W-1:0] sh, input logic [1:0] mode,
                                  output logic [LANES*OUT_W-1:0] od, output logic [LANES-1:0] os);
        int s, p, x, rem, q, half, inc, y;
        s = en ? ((int'(sh) > IN_W - 1) ? IN_W - 1 : int'(sh)) : 0;
        p = 1 << s;
        od = '0;
        os = '0;
        for (int k = 0; k < LANES; k++) begin
            x   = int'($signed(d[k*IN_W +: IN_W]));
            rem = x % p;
            if (rem < 0) rem += p;
            q    = (x - rem) / p;
            half = p / 2;
            inc  = 0;
            if (en && s > 0) begin
                case (mode)
                    2'b01: inc = (rem >= half) ? 1 : 0;
                    2'b10: inc = (rem > half || (rem == half && (q % 2 != 0))) ? 1 : 0;
                    2'b11: inc = (rem > half || (rem == half && x >= 0)) ? 1 : 0;
                    default: inc = 0;
                endcase
            end
            y = q + inc;
            if (y > 127)       begin od[k*OUT_W +: OUT_W] = 8'h7F; os[k] = 1'b1; end
            else if (y < -128) begin od[k*OUT_W +: OUT_W] = 8'h80; os[k] = 1'b1; end
            else                     od[k*OUT_W +: OUT_W] = y[7:0];
        end
    endfunction

    function automatic int sat_add(input int a, input int b);
        return (a + b > 65535) ? 65535 : a + b;
    endfunction

    always @(negedge i_clk) begin
        exp_t e;
        int   nxt;
        if (!i_rst_n) begin
            sb.delete();
            exp_cnt    = 0;
            prev_stall = 1'b0;
            check("rst_valid", o_valid, 1'b0);
            check("rst_cnt", o_sat_cnt, 0);
            check("rst_ready", o_ready, 1'b1);
        end else begin
            check("cnt", o_sat_cnt, exp_cnt);
            if (prev_stall) begin
                check("stall_valid", o_valid, 1'b1);
                check("stall_data", o_data, prev_data);
                check("stall_sat", o_sat, prev_sat);
            end
            nxt = exp_cnt;
            if (o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", o_valid, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("data", o_data, e.d);
                    check("sat", o_sat, e.s);
                    if (e.has_dir) begin
                        check({e.tag, "_lane0"}, o_data[OUT_W-1:0], e.dir_d);
                        check({e.tag, "_sat0"}, o_sat[0], e.dir_s);
                    end
                    nxt = sat_add(exp_cnt, $countones(e.s));
                end
            end
            if (i_clr_cnt) nxt = 0;
            exp_cnt = nxt;
            if (i_valid && o_ready) begin
                model(i_data, i_shift_en, i_shift, i_round_mode, e.d, e.s);
                e.has_dir = cur_has_dir;
                e.dir_d   = cur_dir_d;
                e.dir_s   = cur_dir_s;
                e.tag     = cur_tag;
                sb.push_back(e);
            end
            prev_stall = o_valid && !i_ready;
            prev_data  = o_data;
            prev_sat   = o_sat;
        end
    end

    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            if (ready_rand) i_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // Called just after a rising edge; returns just after the edge that transferred the beat.
    task automatic send(input logic [LANES*IN_W-1:0] d, input logic en,
                        input logic [SHIFT_W-1:0] sh, input logic [1:0] mode);
        int n;
        i_data       = d;
        i_shift_en   = en;
        i_shift      = sh;
        i_round_mode = mode;
        i_valid      = 1'b1;
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!o_ready && n < 1000);
        if (!o_ready) check("send_timeout", o_ready, 1'b1);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic send_dir(input string tag, input logic [IN_W-1:0] x, input logic en,
                            input logic [SHIFT_W-1:0] sh, input logic [1:0] mode,
                            input logic [OUT_W-1:0] ed, input logic es);
        logic [LANES*IN_W-1:0] d;
        for (int k = 0; k < LANES; k++) d[k*IN_W +: IN_W] = IN_W'($urandom);
        d[IN_W-1:0] = x;
        cur_has_dir = 1'b1;
        cur_dir_d   = ed;
        cur_dir_s   = es;
        cur_tag     = tag;
        send(d, en, sh, mode);
        cur_has_dir = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge i_clk);
            #2;
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    endtask

    task automatic clr_cnt();
        i_clr_cnt = 1'b1;
        @(posedge i_clk);
        #1;
        i_clr_cnt = 1'b0;
    endtask

    logic [LANES*IN_W-1:0] all_sat, half_sat, d;

    initial begin
        i_rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_shift_en = 1'b0; i_shift = '0;
        i_round_mode = 2'b00; i_ready = 1'b1; i_clr_cnt = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            all_sat[k*IN_W +: IN_W]  = 16'h7FFF;
            half_sat[k*IN_W +: IN_W] = (k < 16) ? 16'h7FFF : 16'h0000;
        end

        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_data", o_data, 0);
        check("rst_osat", o_sat, 0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("ready_after_rst", o_ready, 1'b1);
        @(posedge i_clk);
        #1;

        // Rounding modes at shift 8.
        send_dir("p25_m0", 16'h0280, 1'b1, 5'd8, 2'b00, 8'h02, 1'b0);
        send_dir("p25_m1", 16'h0280, 1'b1, 5'd8, 2'b01, 8'h03, 1'b0);
        send_dir("p25_m2", 16'h0280, 1'b1, 5'd8, 2'b10, 8'h02, 1'b0);
        send_dir("p25_m3", 16'h0280, 1'b1, 5'd8, 2'b11, 8'h03, 1'b0);
        send_dir("n25_m0", 16'hFD80, 1'b1, 5'd8, 2'b00, 8'hFD, 1'b0);
        send_dir("n25_m1", 16'hFD80, 1'b1, 5'd8, 2'b01, 8'hFE, 1'b0);
        send_dir("n25_m2", 16'hFD80, 1'b1, 5'd8, 2'b10, 8'hFE, 1'b0);
        send_dir("n25_m3", 16'hFD80, 1'b1, 5'd8, 2'b11, 8'hFD, 1'b0);
        send_dir("p15_m2", 16'h0180, 1'b1, 5'd8, 2'b10, 8'h02, 1'b0);
        // Saturation and clamp.
        send_dir("sat_pos", 16'h7FFF, 1'b1, 5'd4, 2'b01, 8'h7F, 1'b1);
        send_dir("sat_neg", 16'h8000, 1'b0, 5'd9, 2'b01, 8'h80, 1'b1);
        send_dir("max_ok",  16'h007F, 1'b1, 5'd0, 2'b01, 8'h7F, 1'b0);
        send_dir("clamp_m0", 16'h4000, 1'b1, 5'd31, 2'b00, 8'h00, 1'b0);
        send_dir("clamp_m1", 16'h4000, 1'b1, 5'd31, 2'b01, 8'h01, 1'b0);
        send_dir("clamp_m2", 16'h4000, 1'b1, 5'd31, 2'b10, 8'h00, 1'b0);
        drain();

        // Random beats with random backpressure and occasional bubbles.
        ready_rand = 1'b1;
        for (int b = 0; b < 40; b++) begin
            for (int k = 0; k < LANES; k++) d[k*IN_W +: IN_W] = IN_W'($urandom);
            send(d, 1'($urandom_range(0, 3) != 0), 5'($urandom), 2'($urandom));
            if ($urandom_range(0, 4) == 0) begin
                @(posedge i_clk);
                #1;
            end
        end
        // Incrementing stream under backpressure: order and stability are checked.
        for (int b = 0; b < 20; b++) begin
            for (int k = 0; k < LANES; k++) d[k*IN_W +: IN_W] = IN_W'((b * 7 + k) & 16'h7F);
            send(d, 1'b0, 5'd0, 2'b00);
        end
        ready_rand = 1'b0;
        i_ready    = 1'b1;
        drain();

        // Three fully saturated beats.
        clr_cnt();
        repeat (3) send(all_sat, 1'b0, 5'd0, 2'b00);
        drain();
        check("cnt_96", o_sat_cnt, 96);

        // Reset with both stages full.
        i_ready = 1'b0;
        send(all_sat, 1'b0, 5'd0, 2'b00);
        send(all_sat, 1'b0, 5'd0, 2'b00);
        @(posedge i_clk);
        #3;
        i_rst_n = 1'b0;
        #1;
        check("midrst_valid", o_valid, 1'b0);
        check("midrst_cnt", o_sat_cnt, 0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        @(negedge i_clk);
        check("midrst_ready", o_ready, 1'b1);
        @(posedge i_clk);
        #1;
        send_dir("post_rst", 16'h0280, 1'b1, 5'd8, 2'b01, 8'h03, 1'b0);
        @(negedge i_clk);
        check("lat_c1", o_valid, 1'b0);
        @(negedge i_clk);
        check("lat_c2", o_valid, 1'b1);
        @(posedge i_clk);
        #1;
        drain();

        // Counter saturation at 0xFFFF.
        clr_cnt();
        for (int b = 0; b < 2047; b++) send(all_sat, 1'b0, 5'd0, 2'b00);
        send(half_sat, 1'b0, 5'd0, 2'b00);
        drain();
        check("cnt_fff0", o_sat_cnt, 16'hFFF0);
        send(all_sat, 1'b0, 5'd0, 2'b00);
        drain();
        check("cnt_ffff", o_sat_cnt, 16'hFFFF);

        // Clear in the same cycle as a saturated output transfer.
        i_ready = 1'b0;
        send(all_sat, 1'b0, 5'd0, 2'b00);
        for (int n = 0; n < 10 && !o_valid; n++) begin
            @(posedge i_clk);
            #1;
        end
        check("clr_wait_valid", o_valid, 1'b1);
        i_ready   = 1'b1;
        i_clr_cnt = 1'b1;
        @(posedge i_clk);
        #1;
        i_clr_cnt = 1'b0;
        check("clr_priority", o_sat_cnt, 0);
        drain();
        @(negedge i_clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/requant_round_sat.md
# requant_round_sat

Multi-lane, parametrised requantiser for the NPU core output path. Each lane takes a signed IN_W accumulator value, optionally arithmetic-right-shifts it by a per-beat shift amount, and rounds with one of four selectable modes. It then saturates the result to signed OUT_W. Beats flow through a 2-stage valid/ready pipeline with full backpressure, and a saturation-event counter is kept for quantisation-calibration debug.

## Interface
- LANES, 32, number of parallel lanes
- IN_W, 16, signed input width per lane (≥ OUT_W+1)
- OUT_W, 8, signed output width per lane
- SHIFT_W, 5, width of shift amount
- CNT_W, 16, saturation counter width

- i_clk  in  1  clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_valid  in  1  input beat valid
- o_ready  out  1  block can accept a beat this cycle
- i_data  in  LANES*IN_W  lane k at [k*IN_W +: IN_W], signed
- i_shift_en  in  1  0: no shift, no rounding (saturate only)
- i_shift  in  SHIFT_W  right-shift amount, sampled with the beat
- i_round_mode  in  2  00 truncate/floor, 01 half-up, 10 half-even, 11 half-away-from-zero
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream accepts output
- o_data  out  LANES*OUT_W  lane k at [k*OUT_W +: OUT_W], signed
- o_sat  out  LANES  per-lane saturation flag, aligned with o_data
- i_clr_cnt  in  1  synchronous clear of o_sat_cnt
- o_sat_cnt  out  CNT_W  running count of saturated lanes

## Operation
- Effective shift s = i_shift_en ? min(i_shift, IN_W-1) : 0. Values of i_shift ≥ IN_W clamp to IN_W-1.
- Stage 1, per lane:
  - q = x >>> s (arithmetic).
  - guard g = x[s-1].
  - sticky r = |x[s-2:0].
  - lsb l = x[s].
  - sign = x[IN_W-1].
  - For s=0: g=r=0. For s=1: r=0.
- Round increment inc, by mode:
  - 00: inc = 0.
  - 01: inc = g.
  - 10: inc = g & (r | l).
  - 11: inc = g & (r | ~sign).
  - inc is forced to 0 when i_shift_en=0.
- Stage 2: y = q + inc, computed in IN_W+1 bits (no wrap).
  - y > 2^(OUT_W-1)-1 → output max, o_sat=1.
  - y < -2^(OUT_W-1) → output min, o_sat=1.
  - Otherwise output y[OUT_W-1:0], o_sat=0.
- Mode and shift are per beat; they travel with the data through stage 1.
- Counter:
  - On each output transfer (o_valid & i_ready), o_sat_cnt += popcount(o_sat).
  - The counter saturates at 2^CNT_W-1 and never wraps.
  - i_clr_cnt has priority: it zeroes the counter, and any increment in that same cycle is discarded.

## Timing
- Latency: exactly 2 cycles from input transfer to o_valid with no stall.
- Throughput: 1 beat/cycle.
- Stage advance:
  - adv2 = ~o_valid | i_ready.
  - Stage 1 advances when its register is empty or adv2 is true.
  - o_ready = ~s1_valid | adv2, a combinational function of registered state and i_ready only.
- Input transfer = i_valid & o_ready.
- While o_valid=1 and i_ready=0:
  - o_data, o_sat and o_valid hold stable.
  - Stage 1 holds if full; no beat is dropped or duplicated.
- Bubbles (i_valid=0) propagate; o_valid drops for exactly the bubble cycles.
- Reset values: o_valid=0, o_data=0, o_sat=0, o_sat_cnt=0, internal valids=0. o_ready=1 while in reset and in the first cycle after.
- Reset asserted mid-stream discards all in-flight beats immediately. The first new beat emerges 2 cycles after its transfer.
- Simultaneous transfer in and out with both stages full: the pipeline shifts by one and no data is lost.
- Saturation compares the full-width y, so IN_W inputs near ±2^(IN_W-1) with s=0 saturate correctly.

## Test plan
- Rounding modes, shift=8, lane0, modes 00/01/10/11:
  - x=0x0280 (2.5) → 2/3/2/3.
  - x=0xFD80 (−2.5) → 0xFD/0xFE/0xFE/0xFD.
  - x=0x0180 (1.5), mode 10 → 2.
- Saturation:
  - x=0x7FFF, shift=4, mode 01 → 0x7F, o_sat=1.
  - x=0x8000, i_shift_en=0 → 0x80, o_sat=1.
  - x=0x007F, shift=0 → 0x7F, o_sat=0.
  - All 32 lanes saturating for 3 beats → o_sat_cnt=96.
- Clamp: i_shift=31, x=0x4000 → s=15, result 0 with g=1; mode 01 → 1, mode 10 → 0.
- Backpressure:
  - Stream 20 incrementing beats with i_ready toggling pseudo-randomly.
  - Output sequence must equal the input sequence, with no loss or duplication.
  - o_data must be stable during every stall.
- Counter:
  - Set o_sat_cnt to 0xFFF0, then send 1 beat with 32 saturated lanes → 0xFFFF.
  - Assert i_clr_cnt in the same cycle as a saturated output transfer → 0.
- Reset mid-stream: assert i_rst_n=0 with both stages full → o_valid=0 and counter 0 immediately. After release, the first beat appears 2 cycles after its transfer.
